multibyte_add_seq: RTL
======================

Name: multibyte_add_seq

Overview:
- Sequencer that performs an NBYTES-wide addition by driving the existing 8-bit combinational adder (Adder_8) one byte per clock, least significant byte first.
- Chains the adder's carry-out back into its carry-in and assembles the wide result.
- Sits directly upstream of Adder_8: it feeds A/B/Cin and consumes Sum/Cout.
- Start/busy/done handshake toward the requesting logic.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..16.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op_a  input  8*NBYTES  operand A, latched on accepted start
- op_b  input  8*NBYTES  operand B, latched on accepted start
- cin  input  1  initial carry-in, latched on accepted start
- add_a  output  8  to adder A
- add_b  output  8  to adder B
- add_cin  output  1  to adder Cin
- add_sum  input  8  from adder Sum
- add_cout  input  1  from adder Cout
- result  output  8*NBYTES  assembled sum
- cout  output  1  final carry-out
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE, idx=0, carry=0.
  - result=0, cout=0, busy=0, done=0.
  - add_a/add_b/add_cin=0.
- IDLE:
  - start=1 at an edge latches op_a, op_b, cin into a_reg, b_reg, carry.
  - The same edge sets idx=0 and moves to RUN.
  - result is not cleared at start; it is overwritten byte by byte.
- RUN:
  - Adder inputs are combinational from registers: add_a=a_reg[8*idx+:8], add_b=b_reg[8*idx+:8], add_cin=carry.
  - Each edge: result[8*idx+:8]<=add_sum, carry<=add_cout, idx<=idx+1.
  - On the edge capturing byte NBYTES-1: cout<=add_cout, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE.
- Latency:
  - start sampled at edge T0; bytes are captured at edges T1..T_NBYTES.
  - done and the final result/cout are visible in the cycle after edge T_NBYTES, i.e. NBYTES cycles after the start edge.
  - Throughput: one operation per NBYTES+2 cycles.
- Output hold: result and cout hold their values from the DONE cycle until the next accepted start.
- busy: busy=1 exactly in RUN.
- add_* outside RUN: add_a, add_b and add_cin are 0 in IDLE and DONE.
- start during RUN: ignored; the latched operands are unaffected by op_a/op_b changes after acceptance.
- Reset mid-operation:
  - Immediate return to IDLE with all reset values.
  - No done pulse; the partial result is discarded.
- Simultaneous rst and start: rst wins.
- Width rules: modulo-2^(8*NBYTES) sum with carry-out in cout. idx is $clog2(NBYTES)-bit, minimum 1 bit. The idx wrap is never reached because the FSM exits RUN at NBYTES-1.
- NBYTES=1: a single RUN cycle, done 1 cycle after the start edge.

Optional Feature:
- Macro MULTIBYTE_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched on accepted start.
  - When sub=1: add_b=~b_reg byte, initial carry forced to 1 (cin ignored), giving result=op_a-op_b.
  - In subtract mode cout=1 means no borrow.
- Undefined:
  - No sub port; addition only.
  - Behaviour identical to the base description.

Test Plan (NBYTES=4, Adder_8 connected to add_*):
1. op_a=0x000000FF, op_b=0x00000001, cin=0, start pulse -> busy high 4 cycles; done pulse 4 cycles after start edge; result=0x00000100, cout=0.
2. op_a=0xFFFFFFFF, op_b=0x00000001, cin=0 -> result=0x00000000, cout=1 (carry ripples through all 4 bytes).
3. op_a=0x12345678, op_b=0x11111111, cin=1 -> result=0x2345678A, cout=0. Then start=1 held high through RUN -> exactly one done pulse; the second operation begins only after returning to IDLE.
4. Start 0xFFFFFFFF+0x00000001, change op_a/op_b on the cycle after start -> result still 0x00000000, cout=1.
5. Assert rst during the 2nd RUN cycle -> next cycle busy=0, done=0, result=0, cout=0, add_*=0. No done pulse afterwards. A new start 0x00000002+0x00000003 -> result=0x00000005.
6. (MULTIBYTE_ADD_SUB_EN) sub=1: op_a=5, op_b=7 -> result=0xFFFFFFFE, cout=0. op_a=7, op_b=5 -> result=0x00000002, cout=1.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: drives an external 8-bit combinational adder one byte per
// clock, LSB first, chaining carry-out back to carry-in, and assembles an
// NBYTES-wide sum. Start/busy/done handshake toward the requester.
// Optional feature macro: MULTIBYTE_ADD_SUB_EN adds a 'sub' input that turns
// the operation into op_a - op_b (two's complement: invert B, carry-in = 1).
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
`ifdef MULTIBYTE_ADD_SUB_EN
  input  logic                  sub,
`endif
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   state, state_n;
  logic [IW-1:0]            idx;
  logic                     carry;
  logic [NBYTES-1:0][7:0]   a_reg;
  logic [NBYTES-1:0][7:0]   b_reg;
  logic [NBYTES-1:0][7:0]   res_q;
  logic                     cout_q;
  logic                     accept;
  logic                     start_carry;
`ifdef MULTIBYTE_ADD_SUB_EN
  logic                     sub_q;
`endif

  assign accept = (state == S_IDLE) && start;

  // Subtraction forces the initial carry to 1 so that A + ~B + 1 = A - B.
`ifdef MULTIBYTE_ADD_SUB_EN
  assign start_carry = sub ? 1'b1 : cin;
`else
  assign start_carry = cin;
`endif

  // Control state, byte index, running carry and the assembled result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx   <= '0;
        carry <= start_carry;
      end else if (state == S_RUN) begin
        res_q[idx] <= add_sum;
        carry      <= add_cout;
        idx        <= idx + 1'b1;
        if (idx == LAST_IDX) begin
          cout_q <= add_cout;
        end
      end
    end
  end

  // Operand capture on an accepted start; operands are pure data, no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= op_a;
      b_reg <= op_b;
`ifdef MULTIBYTE_ADD_SUB_EN
      sub_q <= sub;
`endif
    end
  end

  // Next-state decode and adder drive; adder inputs are zero outside RUN.
  always_comb begin
    state_n = state;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        add_a   = a_reg[idx];
`ifdef MULTIBYTE_ADD_SUB_EN
        add_b   = sub_q ? ~b_reg[idx] : b_reg[idx];
`else
        add_b   = b_reg[idx];
`endif
        add_cin = carry;
        if (idx == LAST_IDX) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign result = res_q;
  assign cout   = cout_q;

endmodule
